// File: rtl/uxn_pkg.sv
// uxn_pkg: shared widths and state types for the uxn CPU and its memory arbiter
package uxn_pkg;
  localparam int ADDR_W = 16;
  localparam int DATA_W = 16;
  typedef enum logic [1:0] {ARB_IDLE, ARB_ISSUE, ARB_RESP} arb_state_t;
  typedef enum logic [1:0] {CPU_RUN, CPU_HALT, CPU_BRK} cpu_state_t;
endpackage

// File: rtl/uxn_mem_arbiter.sv
// uxn_mem_arbiter: shares one synchronous RAM between the fetch and data ports, one access in flight
module uxn_mem_arbiter
  import uxn_pkg::*;
#(
  parameter bit FAIR = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              f_req,
  input  logic [ADDR_W-1:0] f_addr,
  output logic              f_gnt,
  output logic              f_rvalid,
  output logic [DATA_W-1:0] f_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic [DATA_W-1:0] d_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);
  arb_state_t state, state_nx;
  logic win_d, last_d, l_we, pick_d, issue, accept;
  logic [ADDR_W-1:0] l_addr;
  logic [DATA_W-1:0] l_wdata;
  // last_d resets to data so fetch wins the first tie in fair mode
  assign pick_d = d_req & (~f_req | (FAIR ? ~last_d : 1'b1));
  assign accept = (state == ARB_IDLE) & (f_req | d_req);
  assign issue = state == ARB_ISSUE;
  assign mem_en = issue;
  assign mem_we = issue & l_we;
  assign mem_addr = l_addr;
  assign mem_wdata = l_wdata;
  assign f_gnt = issue & ~win_d;
  assign d_gnt = issue & win_d;
  always_comb begin
    state_nx = ARB_IDLE;
    if (state == ARB_IDLE) state_nx = (f_req | d_req) ? ARB_ISSUE : ARB_IDLE;
    else if (state == ARB_ISSUE) state_nx = l_we ? ARB_IDLE : ARB_RESP;
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= ARB_IDLE;
    else state <= state_nx;
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      win_d <= 1'b0;
      last_d <= 1'b1;
      l_we <= 1'b0;
      l_addr <= '0;
      l_wdata <= '0;
      f_rvalid <= 1'b0;
      d_rvalid <= 1'b0;
      f_rdata <= '0;
      d_rdata <= '0;
    end else begin
      if (accept) begin
        win_d <= pick_d;
        last_d <= pick_d;
        l_we <= pick_d & d_we;
        l_addr <= pick_d ? d_addr : f_addr;
        l_wdata <= d_wdata;
      end
      f_rvalid <= (state == ARB_RESP) & ~win_d;
      d_rvalid <= (state == ARB_RESP) & win_d;
      if (state == ARB_RESP && !win_d) f_rdata <= mem_rdata;
      if (state == ARB_RESP && win_d) d_rdata <= mem_rdata;
    end
  end
endmodule

// File: doc/uxn_mem_arbiter.md
UXN_MEM_ARBITER -- requirements
Module: uxn_mem_arbiter

Interface
REQ-001 FAIR, default 1: 1 = round-robin between requesters; 0 = fixed priority, data port wins.
REQ-002 clk  input  1  single clock; all state on rising edge.
REQ-003 rst  input  1  asynchronous, active-low reset.
REQ-004 f_req  input  1  instruction-fetch read request; held until f_gnt.
REQ-005 f_addr  input  16  fetch word address.
REQ-006 f_gnt  output  1  one-cycle pulse: fetch request accepted.
REQ-007 f_rvalid  output  1  one-cycle pulse: f_rdata valid.
REQ-008 f_rdata  output  16  fetch read data.
REQ-009 d_req  input  1  data-port request; held until d_gnt.
REQ-010 d_we  input  1  1 = write, 0 = read.
REQ-011 d_addr  input  16  data word address.
REQ-012 d_wdata  input  16  write data.
REQ-013 d_gnt  output  1  one-cycle pulse: data request accepted.
REQ-014 d_rvalid  output  1  one-cycle pulse: d_rdata valid; reads only.
REQ-015 d_rdata  output  16  data read data.
REQ-016 mem_en  output  1  memory access strobe.
REQ-017 mem_we  output  1  memory write enable; qualified by mem_en.
REQ-018 mem_addr  output  16  memory word address.
REQ-019 mem_wdata  output  16  memory write data.
REQ-020 mem_rdata  input  16  synchronous RAM read data; valid the cycle after mem_en with mem_we=0.

Function
REQ-021 FSM states: IDLE, ISSUE, RESP. One access outstanding at a time.
REQ-022 IDLE: if any req is high, pick the winner, latch its addr/we/wdata and identity, go to ISSUE; otherwise stay in IDLE.
REQ-023 ISSUE: mem_en=1 with the latched fields; winner's gnt=1 for this cycle only; next state is RESP for a read, IDLE for a write.
REQ-024 RESP: register mem_rdata into the winner's rdata and pulse its rvalid the following cycle; then go to IDLE.
REQ-025 Latency: req seen in IDLE at cycle N -> gnt and mem_en at N+1 -> rvalid at N+3 (read); next access can be accepted at N+2 (write) or N+3 (read).
REQ-026 FAIR=1, both req in IDLE: grant the port not granted last; the last-grant register resets to data, so fetch wins the first tie.
REQ-027 FAIR=0, both req: data always wins.
REQ-028 Single requester: granted regardless of FAIR or last-grant.
REQ-029 Fetch is read-only; the f_ path never drives mem_we=1.
REQ-030 A req dropped before gnt is legal and simply not sampled. Once latched, the access completes even if req drops.
REQ-031 Requester inputs may change the cycle after gnt; latched copies are used.
REQ-032 rdata holds its last value between rvalid pulses. At most one gnt and at most one rvalid are high per cycle.
REQ-033 mem_en, gnt and rvalid are 0 in every state other than those listed above.

Reset
REQ-034 rst low: state=IDLE; all gnt, rvalid, mem_en, mem_we = 0; mem_addr, mem_wdata, rdata = 0; last-grant = data.
REQ-035 Reset mid-access: the in-flight read is discarded and no rvalid is issued after reset deasserts.
REQ-036 The first request can be sampled on the first rising edge after deassertion.

Structure
REQ-037 The arb_state_t enum and constants ADDR_W=16 and DATA_W=16 live in shared package uxn_pkg, alongside the CPU state types.
REQ-038 No sub-module is required; the 2-way pick is small enough to stay inline.

Verification
REQ-039 Fetch only, f_addr=0x0010, mem returns 0xBEEF -> f_gnt at N+1, f_rvalid at N+3 with f_rdata=0xBEEF; no d_ activity.
REQ-040 Data write d_addr=0x1234, d_wdata=0xA5A5 -> mem_en=1, mem_we=1, addr 0x1234, data 0xA5A5 for one cycle; no d_rvalid.
REQ-041 FAIR=1, both req held continuously -> grants alternate F,D,F,D; no port waits more than one other access.
REQ-042 FAIR=0, both req held -> d_gnt every access and f_gnt never while d_req is high.
REQ-043 rst asserted the cycle after a read ISSUE -> no rvalid afterwards; all outputs 0; next request is served normally.
REQ-044 d_req pulsed high for one cycle while the arbiter is in RESP -> never granted, mem_en stays low after the current access.
